// File: rtl/cla_seq_adder_if.sv
// Valid/ready operand and result bus of the sequential carry-lookahead adder.
// The slave side is the adder; the master side issues operands and consumes results.
interface cla_seq_adder_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;
    logic             busy;

    modport master (
        output in_valid, a, b, sub, cin, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, zero, busy
    );

    modport slave (
        input  in_valid, a, b, sub, cin, out_ready,
        output in_ready, out_valid, sum, cout, ovf, zero, busy
    );
endinterface

// File: rtl/cla_seq_adder.sv
// Area-optimised WIDTH-bit add/subtract: one 4-bit carry-lookahead slice is reused
// for every nibble, LSB first, so a result takes WIDTH/4 cycles behind valid/ready.
module cla_4_1 (
    input  logic [3:0] px,
    input  logic [3:0] gx,
    input  logic       c_in,
    output logic [3:0] c_out
);
    assign c_out[0] = gx[0] | (px[0] & c_in);
    assign c_out[1] = gx[1] | (px[1] & gx[0]) | (px[1] & px[0] & c_in);
    assign c_out[2] = gx[2] | (px[2] & gx[1]) | (px[2] & px[1] & gx[0])
                    | (px[2] & px[1] & px[0] & c_in);
    assign c_out[3] = gx[3] | (px[3] & gx[2]) | (px[3] & px[2] & gx[1])
                    | (px[3] & px[2] & px[1] & gx[0])
                    | (px[3] & px[2] & px[1] & px[0] & c_in);
endmodule

module cla_seq_adder #(
    parameter int WIDTH = 32
) (
    input logic           clk,
    input logic           rst,
    cla_seq_adder_if.slave bus
);
    localparam int NIB = WIDTH / 4;
    localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;
    logic             out_valid_q, out_valid_d;

    logic [3:0] px, gx, c_out, nibble;

    assign px     = a_q[3:0] ^ b_q[3:0];
    assign gx     = a_q[3:0] & b_q[3:0];
    assign nibble = px ^ {c_out[2:0], carry_q};

    cla_4_1 u_cla (
        .px    (px),
        .gx    (gx),
        .c_in  (carry_q),
        .c_out (c_out)
    );

    // NOTE: every _d gets its hold value first, so no path through this block can infer a latch.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        a_d         = a_q;
        b_d         = b_q;
        carry_d     = carry_q;
        sum_d       = sum_q;
        cout_d      = cout_q;
        ovf_d       = ovf_q;
        zero_d      = zero_q;
        out_valid_d = out_valid_q;
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.a;
                    b_d     = bus.sub ? ~bus.b : bus.b;
                    carry_d = bus.sub ? 1'b1 : bus.cin;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                // Result nibbles enter at the top and settle into place after NIB shifts.
                sum_d   = {nibble, sum_q[WIDTH-1:4]};
                carry_d = c_out[3];
                a_d     = a_q >> 4;
                b_d     = b_q >> 4;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CW'(NIB - 1)) begin
                    cout_d      = c_out[3];
                    ovf_d       = c_out[3] ^ c_out[2];
                    zero_d      = (sum_d == '0);
                    out_valid_d = 1'b1;
                    state_d     = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: non-blocking updates so every register samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        // NOTE: operand and carry registers are reset too, so no X can ever reach the outputs.
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            carry_q     <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            carry_q     <= carry_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
            zero_q      <= zero_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;
    assign bus.zero      = zero_q;
endmodule

// File: tb/tb_cla_seq_adder.sv
// Directed checks of the 32-bit adder plus a randomised 8-bit run against an
// arithmetic golden model, with random result-side stalls.
module tb_cla_seq_adder;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_fail;

    cla_seq_adder_if #(.WIDTH(32)) bus32 ();
    cla_seq_adder_if #(.WIDTH(8))  bus8 ();

    cla_seq_adder #(.WIDTH(32)) dut32 (.clk(clk), .rst(rst), .bus(bus32.slave));
    cla_seq_adder #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one 32-bit operation, wait for the result and check latency and flags.
    task automatic run32(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic sub, input logic cin, input logic [31:0] exp_sum,
                         input logic exp_cout, input logic exp_ovf, input logic exp_zero,
                         input bit release_result);
        int lat;
        bus32.a        = a;
        bus32.b        = b;
        bus32.sub      = sub;
        bus32.cin      = cin;
        bus32.in_valid = 1'b1;
        @(posedge clk); #1;
        bus32.in_valid = 1'b0;
        lat = 0;
        while (!bus32.out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, " latency"}, 64'(lat), 64'd8);
        check({tag, " sum"}, 64'(bus32.sum), 64'(exp_sum));
        check({tag, " cout/ovf/zero"}, {61'd0, bus32.cout, bus32.ovf, bus32.zero},
              {61'd0, exp_cout, exp_ovf, exp_zero});
        if (release_result) begin
            bus32.out_ready = 1'b1;
            @(posedge clk); #1;
            bus32.out_ready = 1'b0;
            check({tag, " back to idle"}, {62'd0, bus32.in_ready, bus32.out_valid}, 64'b10);
        end
    endtask

    // Randomised 8-bit operation checked against plain modular arithmetic.
    task automatic run8(input int idx);
        logic [7:0] a, b, bb, es;
        logic       sub, cin, eo;
        logic [8:0] full;
        int         lat;
        a    = 8'($urandom);
        b    = 8'($urandom);
        sub  = 1'($urandom);
        cin  = 1'($urandom);
        bb   = sub ? ~b : b;
        full = {1'b0, a} + {1'b0, bb} + {8'd0, (sub ? 1'b1 : cin)};
        es   = full[7:0];
        eo   = (a[7] == bb[7]) && (es[7] != a[7]);
        bus8.a        = a;
        bus8.b        = b;
        bus8.sub      = sub;
        bus8.cin      = cin;
        bus8.in_valid = 1'b1;
        @(posedge clk); #1;
        bus8.in_valid = 1'b0;
        bus8.a        = 8'($urandom);
        lat = 0;
        while (!bus8.out_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        repeat ($urandom_range(0, 3)) begin
            @(posedge clk); #1;
        end
        check($sformatf("rand8[%0d] lat/valid/sum/flags", idx),
              {48'd0, 4'(lat), bus8.out_valid, bus8.sum, bus8.cout, bus8.ovf, bus8.zero},
              {48'd0, 4'd2, 1'b1, es, full[8], eo, (es == 8'd0)});
        bus8.out_ready = 1'b1;
        @(posedge clk); #1;
        bus8.out_ready = 1'b0;
    endtask

    initial begin
        bit seen;
        n_cmp  = 0;
        n_fail = 0;
        rst    = 1'b1;
        {bus32.in_valid, bus32.out_ready, bus32.sub, bus32.cin} = '0;
        bus32.a = '0;
        bus32.b = '0;
        {bus8.in_valid, bus8.out_ready, bus8.sub, bus8.cin} = '0;
        bus8.a = '0;
        bus8.b = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        check("reset handshake", {61'd0, bus32.in_ready, bus32.busy, bus32.out_valid}, 64'b100);
        check("reset sum", 64'(bus32.sum), 64'd0);
        check("reset flags", {61'd0, bus32.cout, bus32.ovf, bus32.zero}, 64'd0);

        run32("add wrap", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1);
        run32("sub 5-7",  32'h0000_0005, 32'h0000_0007, 1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 1);
        run32("sub 7-5",  32'h0000_0007, 32'h0000_0005, 1'b1, 1'b0, 32'h0000_0002, 1'b1, 1'b0, 1'b0, 1);
        run32("add ovf+", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1);
        run32("add ovf-", 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1, 1);
        run32("add cin",  32'h0000_000F, 32'h0000_0010, 1'b0, 1'b1, 32'h0000_0020, 1'b0, 1'b0, 1'b0, 1);
        run32("sub cin ignored", 32'h0000_000A, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_0007, 1'b1, 1'b0, 1'b0, 1);
        run32("sub equal", 32'h1234_5678, 32'h1234_5678, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1);
        run32("sub ovf",  32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 1);
        run32("carry chain", 32'h0FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h1000_0000, 1'b0, 1'b0, 1'b0, 1);

        // Result held in DONE while the consumer stalls; new operands are ignored.
        run32("hold", 32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0, 32'h0000_0003, 1'b0, 1'b0, 1'b0, 0);
        for (int i = 0; i < 10; i++) begin
            bus32.in_valid = (i % 2 == 0);
            bus32.a        = 32'd100;
            bus32.b        = 32'd100;
            @(posedge clk); #1;
            check($sformatf("hold cycle %0d valid/ready/sum", i),
                  {30'd0, bus32.out_valid, bus32.in_ready, bus32.sum}, {30'd0, 1'b1, 1'b0, 32'h3});
        end
        bus32.in_valid  = 1'b0;
        bus32.out_ready = 1'b1;
        @(posedge clk); #1;
        bus32.out_ready = 1'b0;
        check("hold release", {30'd0, bus32.out_valid, bus32.in_ready, bus32.sum}, {30'd0, 1'b0, 1'b1, 32'h3});
        run32("after hold", 32'h0000_0010, 32'h0000_0020, 1'b0, 1'b0, 32'h0000_0030, 1'b0, 1'b0, 1'b0, 1);

        // Reset during RUN discards the operation.
        bus32.a        = 32'hDEAD_BEEF;
        bus32.b        = 32'h1111_1111;
        bus32.sub      = 1'b0;
        bus32.cin      = 1'b0;
        bus32.in_valid = 1'b1;
        @(posedge clk); #1;
        bus32.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mid-run rst state", {61'd0, bus32.in_ready, bus32.busy, bus32.out_valid}, 64'b100);
        check("mid-run rst sum", 64'(bus32.sum), 64'd0);
        seen = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (bus32.out_valid) seen = 1'b1;
        end
        check("mid-run rst no result", 64'(seen), 64'd0);
        run32("after rst", 32'h0000_1234, 32'h0000_4321, 1'b0, 1'b0, 32'h0000_5555, 1'b0, 1'b0, 1'b0, 1);

        // Reset and accept on the same edge: reset wins, nothing is accepted.
        bus32.in_valid = 1'b1;
        rst            = 1'b1;
        @(posedge clk); #1;
        rst            = 1'b0;
        bus32.in_valid = 1'b0;
        check("rst beats accept", {62'd0, bus32.in_ready, bus32.busy}, 64'b10);
        seen = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (bus32.out_valid || bus32.busy) seen = 1'b1;
        end
        check("rst beats accept idle", 64'(seen), 64'd0);

        for (int i = 0; i < 2000; i++) run8(i);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
